// File: rtl/fpu_req_ctrl.sv
// fpu_req_ctrl: initiator-side controller for a fixed-latency half-precision FPU.
//
// Accepts tagged requests over valid/ready and issues them straight to the FPU
// operand inputs. It tracks each issued op through a {valid, tag} shadow pipe
// that matches the FPU latency, and captures results into a response FIFO
// drained over valid/ready. The FPU cannot stall, so admission is credit based:
// an op is only accepted while (in flight + queued) < FIFO_DEPTH. This
// guarantees every result has a FIFO slot when it emerges.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset (shared with FPU)
//   req_valid/req_ready           request handshake
//   req_opA/req_opB/req_op/req_tag  request operands, opcode and opaque tag
//   fpu_opA/fpu_opB/fpu_op        FPU inputs; zero unless a request is accepted
//   fpu_result/fpu_overflow/fpu_underflow/fpu_inexact  FPU outputs
//   rsp_valid/rsp_ready           response handshake
//   rsp_result/rsp_flags/rsp_tag  FIFO head; flags = {inexact, underflow, overflow}
module fpu_req_ctrl #(
    parameter int unsigned PIPELINE_DEPTH = 3,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TAG_W          = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [15:0]      req_opA,
    input  logic [15:0]      req_opB,
    input  logic [1:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic [15:0]      fpu_opA,
    output logic [15:0]      fpu_opB,
    output logic [1:0]       fpu_op,
    input  logic [15:0]      fpu_result,
    input  logic             fpu_overflow,
    input  logic             fpu_underflow,
    input  logic             fpu_inexact,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_result,
    output logic [2:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic                      accept;
    logic                      capture;
    logic                      pop;

    logic [PIPELINE_DEPTH-1:0] pipe_v;
    logic [TAG_W-1:0]          pipe_tag [PIPELINE_DEPTH];

    logic [15:0]               mem_result [FIFO_DEPTH];
    logic [2:0]                mem_flags  [FIFO_DEPTH];
    logic [TAG_W-1:0]          mem_tag    [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;

    logic [CNT_W-1:0]          inflight_cnt;
    logic [CNT_W-1:0]          fifo_count;
    logic [CNT_W:0]            credit_used;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        // Explicit wrap so non-power-of-2 depths work.
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Admission uses registered counts only, so a pop frees credit next cycle.
    assign credit_used = {1'b0, inflight_cnt} + {1'b0, fifo_count};
    assign req_ready   = credit_used < (CNT_W + 1)'(FIFO_DEPTH);
    assign accept      = req_valid && req_ready;
    assign capture     = pipe_v[PIPELINE_DEPTH-1];
    assign rsp_valid   = (fifo_count != '0);
    assign pop         = rsp_valid && rsp_ready;

    always_comb begin
        fpu_opA = '0;
        fpu_opB = '0;
        fpu_op  = '0;
        if (accept) begin
            fpu_opA = req_opA;
            fpu_opB = req_opB;
            fpu_op  = req_op;
        end
    end

    // Shadow pipe: last stage is valid in the same cycle the FPU result is.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_v <= '0;
            for (int i = 0; i < PIPELINE_DEPTH; i++) begin
                pipe_tag[i] <= '0;
            end
        end else begin
            pipe_v[0]   <= accept;
            pipe_tag[0] <= req_tag;
            for (int i = 1; i < PIPELINE_DEPTH; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_cnt <= '0;
        end else if (accept && !capture) begin
            inflight_cnt <= inflight_cnt + CNT_W'(1);
        end else if (!accept && capture) begin
            inflight_cnt <= inflight_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (capture && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (!capture && pop) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
            if (capture) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
        end
    end

    // Storage needs no reset; the outputs are gated by rsp_valid below.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem_result[wr_ptr] <= fpu_result;
            mem_flags[wr_ptr]  <= {fpu_inexact, fpu_underflow, fpu_overflow};
            mem_tag[wr_ptr]    <= pipe_tag[PIPELINE_DEPTH-1];
        end
    end

    assign rsp_result = rsp_valid ? mem_result[rd_ptr] : '0;
    assign rsp_flags  = rsp_valid ? mem_flags[rd_ptr]  : '0;
    assign rsp_tag    = rsp_valid ? mem_tag[rd_ptr]    : '0;

endmodule
